rf_multiport: RTL and testbench

//  Parametrised core register file for the next core generation.

---
 rtl/rf_multiport.sv | 94 +++++++++
 tb/tb_rf_multiport.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rf_multiport.sv
// Multi-port core register file: two read-only input words, FLAGS, IP and GPRs,
// with highest-port-wins write arbitration, optional write-to-read bypass and IP auto-increment.
module rf_multiport #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int WR_PORTS      = 4,
  parameter int RD_PORTS      = 10,
  parameter int BYPASS        = 1,
  parameter int IP_STEP       = 4
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [RD_PORTS-1:0][ADDRESS_WIDTH-1:0]    rd_sel_i,
  output logic [RD_PORTS-1:0][DATA_WIDTH-1:0]       rd_data_o,
  input  logic [WR_PORTS-1:0][ADDRESS_WIDTH-1:0]    wr_sel_i,
  input  logic [WR_PORTS-1:0][DATA_WIDTH-1:0]       wr_data_i,
  input  logic [WR_PORTS-1:0]                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]                     main_input_i,
  input  logic [DATA_WIDTH-1:0]                     inst_input_i,
  input  logic [DATA_WIDTH-1:0]                     flags_i,
  input  logic                                      flags_we_i,
  input  logic                                      ip_inc_i,
  output logic [DATA_WIDTH-1:0]                     instr_ptr_o,
  output logic [DATA_WIDTH-1:0]                     flags_o,
  output logic                                      kernel_o,
  output logic                                      wr_conflict_o,
  output logic                                      ro_write_o
);

  localparam int UNITS    = 2**ADDRESS_WIDTH;
  localparam int FLAGS_A  = 2;
  localparam int IP_A     = 3;
  localparam int KERNEL_A = 4;
  localparam logic [ADDRESS_WIDTH-1:0] FIRST_RW = ADDRESS_WIDTH'(2);

  logic [DATA_WIDTH-1:0] regs_p0  [2:UNITS-1];
  logic [DATA_WIDTH-1:0] win_data [UNITS];
  logic [DATA_WIDTH-1:0] cur      [UNITS];
  logic [UNITS-1:0]      hit;
  logic                  collide;
  logic                  ro_hit;

  function automatic logic [DATA_WIDTH-1:0] ip_advance(input logic [DATA_WIDTH-1:0] ip);
    return ip + DATA_WIDTH'(IP_STEP);
  endfunction

  // Arbitration: ports scanned low to high so the highest enabled port per address overwrites.
  always_comb begin
    hit     = '0;
    collide = 1'b0;
    ro_hit  = 1'b0;
    for (int a = 0; a < UNITS; a++) win_data[a] = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wr_en_i[p]) begin
        if (hit[wr_sel_i[p]]) collide = 1'b1;
        if (wr_sel_i[p] < FIRST_RW) ro_hit = 1'b1;
        hit[wr_sel_i[p]]      = 1'b1;
        win_data[wr_sel_i[p]] = wr_data_i[p];
      end
    end
  end

  // Register stage: port writes outrank flags_we_i / ip_inc_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int a = 2; a < UNITS; a++) regs_p0[a] <= '0;
      wr_conflict_o <= 1'b0;
      ro_write_o    <= 1'b0;
    end else begin
      wr_conflict_o <= collide;
      ro_write_o    <= ro_hit;
      for (int a = 2; a < UNITS; a++) begin
        if (hit[a]) regs_p0[a] <= win_data[a];
      end
      if (!hit[FLAGS_A] && flags_we_i) regs_p0[FLAGS_A] <= flags_i;
      if (!hit[IP_A] && ip_inc_i)      regs_p0[IP_A]    <= ip_advance(regs_p0[IP_A]);
    end
  end

  // Read view: inputs at 0/1 are never bypassed; bypass shows port writes only.
  always_comb begin
    cur[0] = main_input_i;
    cur[1] = inst_input_i;
    for (int a = 2; a < UNITS; a++) begin
      cur[a] = ((BYPASS != 0) && hit[a]) ? win_data[a] : regs_p0[a];
    end
    for (int r = 0; r < RD_PORTS; r++) rd_data_o[r] = cur[rd_sel_i[r]];
  end

  assign instr_ptr_o = regs_p0[IP_A];
  assign flags_o     = regs_p0[FLAGS_A];
  assign kernel_o    = regs_p0[KERNEL_A][0];

endmodule

// File: tb/tb_rf_multiport.sv
// Bench for rf_multiport: a bypassing and a non-bypassing instance share every input,
// with expected write results queued at stimulus time and popped when read back.
module tb_rf_multiport;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int WP = 4;
  localparam int RP = 10;

  logic clk = 1'b0;
  logic rst;
  logic [RP-1:0][AW-1:0] rd_sel;
  logic [RP-1:0][DW-1:0] rd_data, rd_data_nb;
  logic [WP-1:0][AW-1:0] wr_sel;
  logic [WP-1:0][DW-1:0] wr_data;
  logic [WP-1:0]         wr_en;
  logic [DW-1:0] main_in, inst_in, flags_in;
  logic          flags_we, ip_inc;
  logic [DW-1:0] ip, ip_nb, flags, flags_nb;
  logic          kernel, kernel_nb, conflict, conflict_nb, ro, ro_nb;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } exp_t;
  exp_t sb_q[$];
  exp_t e;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rf_multiport #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_PORTS(WP), .RD_PORTS(RP),
                 .BYPASS(1), .IP_STEP(4)) dut (
    .clk_i(clk), .rst_i(rst), .rd_sel_i(rd_sel), .rd_data_o(rd_data),
    .wr_sel_i(wr_sel), .wr_data_i(wr_data), .wr_en_i(wr_en),
    .main_input_i(main_in), .inst_input_i(inst_in), .flags_i(flags_in),
    .flags_we_i(flags_we), .ip_inc_i(ip_inc), .instr_ptr_o(ip), .flags_o(flags),
    .kernel_o(kernel), .wr_conflict_o(conflict), .ro_write_o(ro));

  rf_multiport #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WR_PORTS(WP), .RD_PORTS(RP),
                 .BYPASS(0), .IP_STEP(4)) dut_nb (
    .clk_i(clk), .rst_i(rst), .rd_sel_i(rd_sel), .rd_data_o(rd_data_nb),
    .wr_sel_i(wr_sel), .wr_data_i(wr_data), .wr_en_i(wr_en),
    .main_input_i(main_in), .inst_input_i(inst_in), .flags_i(flags_in),
    .flags_we_i(flags_we), .ip_inc_i(ip_inc), .instr_ptr_o(ip_nb), .flags_o(flags_nb),
    .kernel_o(kernel_nb), .wr_conflict_o(conflict_nb), .ro_write_o(ro_nb));

  task automatic idle();
    wr_en = '0; wr_sel = '0; wr_data = '0;
    flags_we = 1'b0; ip_inc = 1'b0; flags_in = '0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = '1; wr_sel = '1; wr_data = '1; main_in = '1; inst_in = '1;
    flags_in = '1; flags_we = 1'b1; ip_inc = 1'b1; rd_sel = '1;
    tick(); tick();
    idle();
    for (int r = 0; r < RP; r++) rd_sel[r] = AW'(2 + r);
    #1;
    n_cmp++; if (ip !== 32'h0) begin n_fail++; $display("FAIL reset_ip: got %h want 0", ip); end
    n_cmp++; if (flags !== 32'h0) begin n_fail++; $display("FAIL reset_flags: got %h want 0", flags); end
    n_cmp++; if ({kernel, conflict, ro} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl: got %b want 000", {kernel, conflict, ro}); end
    n_cmp++; if ({kernel_nb, conflict_nb, ro_nb} !== 3'b000) begin n_fail++; $display("FAIL reset_ctl_nb: got %b want 000", {kernel_nb, conflict_nb, ro_nb}); end
    for (int r = 0; r < RP; r++) begin
      n_cmp++; if (rd_data[r] !== 32'h0) begin n_fail++; $display("FAIL reset_gpr%0d: got %h want 0", r + 2, rd_data[r]); end
    end
    for (int r = 0; r < 4; r++) rd_sel[r] = AW'(12 + r);
    #1;
    for (int r = 0; r < 4; r++) begin
      n_cmp++; if (rd_data_nb[r] !== 32'h0) begin n_fail++; $display("FAIL reset_gpr%0d: got %h want 0", r + 12, rd_data_nb[r]); end
    end
    rst = 1'b0;
    main_in = 32'hCAFE_0000;
  endtask

  task automatic test_write_priority();
    idle();
    wr_en = 4'b1001; wr_sel[0] = 4'd5; wr_sel[3] = 4'd5;
    wr_data[0] = 32'h11; wr_data[3] = 32'h33;
    sb_q.push_back('{addr: 4'd5, data: 32'h33});
    tick(); idle();
    e = sb_q.pop_front();
    rd_sel[0] = e.addr; #1;
    n_cmp++; if (rd_data_nb[0] !== e.data) begin n_fail++; $display("FAIL prio_rd: got %h want %h", rd_data_nb[0], e.data); end
    n_cmp++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL prio_conflict: got %b want 1", conflict); end
    n_cmp++; if (ro !== 1'b0) begin n_fail++; $display("FAIL prio_ro: got %b want 0", ro); end
    tick();
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL prio_conflict_clear: got %b want 0", conflict); end
  endtask

  task automatic test_read_only();
    idle();
    inst_in = 32'h1234;
    wr_en[1] = 1'b1; wr_sel[1] = 4'd1; wr_data[1] = 32'hDEAD;
    rd_sel[1] = 4'd1; rd_sel[0] = 4'd0; #1;
    n_cmp++; if (rd_data[1] !== 32'h1234) begin n_fail++; $display("FAIL ro_nobypass: got %h want 1234", rd_data[1]); end
    tick(); idle(); #1;
    n_cmp++; if (rd_data[1] !== 32'h1234) begin n_fail++; $display("FAIL ro_rd1: got %h want 1234", rd_data[1]); end
    n_cmp++; if (rd_data[0] !== 32'hCAFE_0000) begin n_fail++; $display("FAIL ro_rd0: got %h want cafe0000", rd_data[0]); end
    n_cmp++; if (ro !== 1'b1) begin n_fail++; $display("FAIL ro_flag: got %b want 1", ro); end
    n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL ro_conflict: got %b want 0", conflict); end
    tick();
    n_cmp++; if (ro !== 1'b0) begin n_fail++; $display("FAIL ro_flag_clear: got %b want 0", ro); end
  endtask

  task automatic test_ip();
    idle();
    wr_en[0] = 1'b1; wr_sel[0] = 4'd3; wr_data[0] = 32'hFFFF_FFFC;
    tick(); idle();
    n_cmp++; if (ip !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL ip_jump: got %h want fffffffc", ip); end
    ip_inc = 1'b1;
    tick();
    n_cmp++; if (ip !== 32'h0) begin n_fail++; $display("FAIL ip_wrap: got %h want 0", ip); end
    wr_en[2] = 1'b1; wr_sel[2] = 4'd3; wr_data[2] = 32'h100; rd_sel[0] = 4'd3; #1;
    n_cmp++; if (rd_data[0] !== 32'h100) begin n_fail++; $display("FAIL ip_bypass: got %h want 100", rd_data[0]); end
    n_cmp++; if (rd_data_nb[0] !== 32'h0) begin n_fail++; $display("FAIL ip_nobypass: got %h want 0", rd_data_nb[0]); end
    tick(); idle();
    n_cmp++; if (ip !== 32'h100) begin n_fail++; $display("FAIL ip_write_over_inc: got %h want 100", ip); end
    ip_inc = 1'b1; #1;
    n_cmp++; if (rd_data[0] !== 32'h100) begin n_fail++; $display("FAIL ip_inc_not_bypassed: got %h want 100", rd_data[0]); end
    tick(); idle();
    n_cmp++; if (ip !== 32'h104) begin n_fail++; $display("FAIL ip_inc: got %h want 104", ip); end
  endtask

  task automatic test_flags_kernel();
    idle();
    flags_we = 1'b1; flags_in = 32'hA;
    wr_en[0] = 1'b1; wr_sel[0] = 4'd2; wr_data[0] = 32'h5;
    tick(); idle();
    n_cmp++; if (flags !== 32'h5) begin n_fail++; $display("FAIL flags_port_wins: got %h want 5", flags); end
    flags_we = 1'b1; flags_in = 32'hA; rd_sel[0] = 4'd2; #1;
    n_cmp++; if (rd_data[0] !== 32'h5) begin n_fail++; $display("FAIL flags_we_not_bypassed: got %h want 5", rd_data[0]); end
    tick(); idle();
    n_cmp++; if (flags !== 32'hA) begin n_fail++; $display("FAIL flags_we: got %h want a", flags); end
    wr_en[1] = 1'b1; wr_sel[1] = 4'd4; wr_data[1] = 32'h1; rd_sel[0] = 4'd4; #1;
    n_cmp++; if (kernel !== 1'b0) begin n_fail++; $display("FAIL kernel_not_bypassed: got %b want 0", kernel); end
    n_cmp++; if (rd_data[0] !== 32'h1) begin n_fail++; $display("FAIL gpr4_bypass: got %h want 1", rd_data[0]); end
    tick(); idle();
    n_cmp++; if (kernel !== 1'b1) begin n_fail++; $display("FAIL kernel_set: got %b want 1", kernel); end
    wr_en[2] = 1'b1; wr_sel[2] = 4'd4; wr_data[2] = 32'hFFFF_FFFE;
    tick(); idle();
    n_cmp++; if (kernel !== 1'b0) begin n_fail++; $display("FAIL kernel_clear: got %b want 0", kernel); end
  endtask

  task automatic test_bypass();
    idle();
    wr_en[3] = 1'b1; wr_sel[3] = 4'd9; wr_data[3] = 32'h77; rd_sel[2] = 4'd9; #1;
    n_cmp++; if (rd_data[2] !== 32'h77) begin n_fail++; $display("FAIL bypass_same_cycle: got %h want 77", rd_data[2]); end
    n_cmp++; if (rd_data_nb[2] !== 32'h0) begin n_fail++; $display("FAIL nobypass_old: got %h want 0", rd_data_nb[2]); end
    tick(); idle(); #1;
    n_cmp++; if (rd_data_nb[2] !== 32'h77) begin n_fail++; $display("FAIL nobypass_next: got %h want 77", rd_data_nb[2]); end
  endtask

  task automatic test_back_to_back();
    idle();
    wr_en = 4'b0011; wr_sel[0] = 4'd0; wr_sel[1] = 4'd0;
    wr_data[0] = 32'h1; wr_data[1] = 32'h2;
    tick(); idle();
    n_cmp++; if ({conflict, ro} !== 2'b11) begin n_fail++; $display("FAIL ro_collision: got %b want 11", {conflict, ro}); end
    wr_en = 4'b1100; wr_sel[2] = 4'd7; wr_sel[3] = 4'd7;
    wr_data[2] = 32'hA7; wr_data[3] = 32'hB7;
    sb_q.push_back('{addr: 4'd7, data: 32'hB7});
    tick(); idle();
    e = sb_q.pop_front(); rd_sel[0] = e.addr; #1;
    n_cmp++; if ({conflict, ro} !== 2'b10) begin n_fail++; $display("FAIL conflict_repeat: got %b want 10", {conflict, ro}); end
    n_cmp++; if (rd_data_nb[0] !== e.data) begin n_fail++; $display("FAIL b2b_rd: got %h want %h", rd_data_nb[0], e.data); end
    tick();
    n_cmp++; if ({conflict, ro} !== 2'b00) begin n_fail++; $display("FAIL b2b_clear: got %b want 00", {conflict, ro}); end
  endtask

  task automatic test_random_writes();
    int port;
    for (int i = 0; i < 16; i++) begin
      idle();
      port = int'($urandom_range(0, WP - 1));
      wr_en[port] = 1'b1;
      wr_sel[port] = AW'($urandom_range(5, 15));
      wr_data[port] = $urandom;
      sb_q.push_back('{addr: wr_sel[port], data: wr_data[port]});
      tick(); idle();
      e = sb_q.pop_front();
      rd_sel[i % RP] = e.addr; #1;
      n_cmp++; if (rd_data_nb[i % RP] !== e.data) begin n_fail++; $display("FAIL rand_rd%0d addr %0d: got %h want %h", i, e.addr, rd_data_nb[i % RP], e.data); end
      n_cmp++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rand_conflict%0d: got %b want 0", i, conflict); end
    end
  endtask

  initial begin
    rst = 1'b0; rd_sel = '0; main_in = '0; inst_in = '0;
    idle();
    test_reset();
    test_write_priority();
    test_read_only();
    test_ip();
    test_flags_kernel();
    test_bypass();
    test_back_to_back();
    test_random_writes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
